// File: rtl/buff_uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART host.
package buff_uart_pkg;

   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

   // Clock cycles needed to shift one full frame out at the line rate.
   function automatic int unsigned cycles_per_frame(input int unsigned clock_freq,
                                                    input int unsigned baud_rate,
                                                    input int unsigned frame_bits);
      return (clock_freq / baud_rate) * frame_bits;
   endfunction

   // Width that holds every credit value from 0 up to and including depth.
   function automatic int unsigned credit_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/buff_uart_credit_counter.sv
// Tracks free TX-FIFO slots: one credit per accepted byte, one credit back per frame time.
module buff_uart_credit_counter
   import buff_uart_pkg::*;
#(
   parameter int unsigned fifo_length  = 16,
   parameter int unsigned frame_cycles = 480
) (
   input  logic clock,
   input  logic reset,
   input  logic consume,
   output logic has_credit
);

   localparam int unsigned cnt_width = credit_width(fifo_length);
   localparam int unsigned tmr_width = $clog2(frame_cycles + 1);
   localparam logic [cnt_width-1:0] credits_full = cnt_width'(fifo_length);
   localparam logic [tmr_width-1:0] timer_last   = tmr_width'(frame_cycles - 1);

   logic [cnt_width-1:0] credits_q, credits_d;
   logic [tmr_width-1:0] timer_q, timer_d;
   logic                 below_full, refill, take;

   assign has_credit = (credits_q != '0);

   // Next credit count and refill timer; simultaneous take and refill cancel out.
   always_comb begin
      below_full = (credits_q != credits_full);
      refill     = below_full && (timer_q == timer_last);
      take       = consume && has_credit;
      credits_d  = credits_q;
      if (refill && !take) begin
         credits_d = credits_q + cnt_width'(1);
      end else if (take && !refill) begin
         credits_d = credits_q - cnt_width'(1);
      end
      // The timer only runs while the modelled FIFO holds something.
      timer_d = (below_full && !refill) ? timer_q + tmr_width'(1) : '0;
   end

   // Credit and timer state.
   always_ff @(posedge clock) begin
      if (reset) begin
         credits_q <= credits_full;
         timer_q   <= '0;
      end else begin
         credits_q <= credits_d;
         timer_q   <= timer_d;
      end
   end

endmodule

// File: rtl/buff_uart_host.sv
// Bus-side initiator for the buffered UART register port: paced TX writes, RX reads.
module buff_uart_host
   import buff_uart_pkg::*;
#(
   parameter int unsigned width         = 8,
   parameter int unsigned address_width = 4,
   parameter int unsigned rx_address    = 0,
   parameter int unsigned tx_address    = 0,
   parameter int unsigned fifo_length   = 16,
   parameter int unsigned baud_rate     = 9600,
   parameter int unsigned clock_freq    = 460800,
   parameter int unsigned frame_bits    = 10,
   parameter int unsigned read_latency  = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [width-1:0]         tx_data,
   input  logic                     rd_req_valid,
   output logic                     rd_req_ready,
   output logic                     rd_resp_valid,
   input  logic                     rd_resp_ready,
   output logic [width-1:0]         rd_resp_data,
   output logic                     read_enable,
   output logic                     write_enable,
   output logic [address_width-1:0] active_address,
   output logic [width-1:0]         data_in,
   input  logic [width-1:0]         data_out
);

   localparam int unsigned frame_cycles = cycles_per_frame(clock_freq, baud_rate, frame_bits);
   localparam logic [address_width-1:0] tx_addr = address_width'(tx_address);
   localparam logic [address_width-1:0] rx_addr = address_width'(rx_address);
   localparam logic [1:0] wait_last = 2'(read_latency - 1);

   state_t     state_q;
   logic       rr_read_q;  // 1: a read wins the next contested cycle
   logic [1:0] wait_q;
   logic       has_credit, tx_accept, rd_accept;

   buff_uart_credit_counter #(
      .fifo_length  (fifo_length),
      .frame_cycles (frame_cycles)
   ) u_credit (
      .clock      (clock),
      .reset      (reset),
      .consume    (tx_accept),
      .has_credit (has_credit)
   );

   // Round-robin ready; gated by reset so nothing is accepted in a reset cycle.
   always_comb begin
      tx_ready     = !reset && (state_q == IDLE) && has_credit && !(rd_req_valid && rr_read_q);
      rd_req_ready = !reset && (state_q == IDLE) && !(tx_valid && has_credit && !rr_read_q);
      tx_accept    = tx_valid && tx_ready;
      rd_accept    = rd_req_valid && rd_req_ready;
   end

   // Bus sequencer with registered UART-side and response outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         rr_read_q      <= 1'b1;
         wait_q         <= '0;
         read_enable    <= 1'b0;
         write_enable   <= 1'b0;
         active_address <= '0;
         data_in        <= '0;
         rd_resp_valid  <= 1'b0;
         rd_resp_data   <= '0;
      end else begin
         read_enable  <= 1'b0;
         write_enable <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (tx_accept) begin
                  state_q        <= WRITE;
                  write_enable   <= 1'b1;
                  active_address <= tx_addr;
                  data_in        <= tx_data;
                  rr_read_q      <= !rr_read_q;
               end else if (rd_accept) begin
                  state_q        <= READ;
                  read_enable    <= 1'b1;
                  active_address <= rx_addr;
                  rr_read_q      <= !rr_read_q;
               end
            end
            WRITE: state_q <= IDLE;
            READ: begin
               state_q <= WAIT;
               wait_q  <= '0;
            end
            WAIT: begin
               // Last WAIT cycle is the one where data_out carries the read result.
               if (wait_q == wait_last) begin
                  rd_resp_data  <= data_out;
                  rd_resp_valid <= 1'b1;
                  state_q       <= RESP;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end
            RESP: begin
               if (rd_resp_ready) begin
                  rd_resp_valid <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_buff_uart_host.sv
// Randomized bench for buff_uart_host with a transaction-timing reference model.
module tb_buff_uart_host;

   localparam int unsigned rd_lat      = 2;
   localparam int          max_credits = 16;
   localparam int          frame       = 480;
   localparam logic [3:0]  rx_addr     = 4'h3;
   localparam logic [3:0]  tx_addr     = 4'h9;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] tx_data = 8'h00;
   logic       rd_req_valid = 1'b0;
   logic       rd_req_ready;
   logic       rd_resp_valid;
   logic       rd_resp_ready = 1'b0;
   logic [7:0] rd_resp_data;
   logic       read_enable;
   logic       write_enable;
   logic [3:0] active_address;
   logic [7:0] data_in;
   logic [7:0] data_out = 8'h00;

   buff_uart_host #(
      .rx_address   (3),
      .tx_address   (9),
      .read_latency (rd_lat)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .tx_data        (tx_data),
      .rd_req_valid   (rd_req_valid),
      .rd_req_ready   (rd_req_ready),
      .rd_resp_valid  (rd_resp_valid),
      .rd_resp_ready  (rd_resp_ready),
      .rd_resp_data   (rd_resp_data),
      .read_enable    (read_enable),
      .write_enable   (write_enable),
      .active_address (active_address),
      .data_in        (data_in),
      .data_out       (data_out)
   );

   always #5 clock = ~clock;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int          cyc   = 0;

   // Reference model: timing of each transaction as cycle numbers.
   int         m_credits, m_refill_end;
   bit         m_ptr_read, m_rd_pending;
   int         m_wr_cycle, m_rd_cycle, m_resp_cycle, m_idle_from;
   logic [7:0] m_wr_byte, m_resp_byte, m_din, m_rdata;
   logic [3:0] m_addr;
   bit         m_tx_acc, m_rd_acc;
   bit         rd_force;
   logic [7:0] rd_force_byte;
   logic [7:0] sched [int];  // UART read data, keyed by the cycle it appears on data_out
   bit         obs_we, obs_re, obs_rv;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_credits    = max_credits;
      m_refill_end = -1;
      m_ptr_read   = 1'b1;
      m_rd_pending = 1'b0;
      m_wr_cycle   = -1;
      m_rd_cycle   = -1;
      m_resp_cycle = -1;
      m_idle_from  = cyc + 1;
      m_din        = 8'h00;
      m_rdata      = 8'h00;
      m_addr       = 4'h0;
   endtask

   task automatic model_cycle();
      logic idle, crd, e_txr, e_rdr, e_we, e_re, e_rv, below, refill;
      int   nc;
      idle  = (cyc >= m_idle_from) && !m_rd_pending;
      crd   = (m_credits != 0);
      e_txr = !reset && idle && crd && !(rd_req_valid && m_ptr_read);
      e_rdr = !reset && idle && !(tx_valid && crd && !m_ptr_read);
      e_we  = (cyc == m_wr_cycle);
      e_re  = (cyc == m_rd_cycle);
      e_rv  = m_rd_pending && (cyc >= m_resp_cycle);
      if (e_we) begin
         m_addr = tx_addr;
         m_din  = m_wr_byte;
      end
      if (e_re) m_addr = rx_addr;
      if (m_rd_pending && cyc == m_resp_cycle) m_rdata = m_resp_byte;

      check_val("tx_ready", tx_ready, e_txr);
      check_val("rd_req_ready", rd_req_ready, e_rdr);
      check_val("write_enable", write_enable, e_we);
      check_val("read_enable", read_enable, e_re);
      check_val("enable_overlap", write_enable && read_enable, 1'b0);
      check_val("active_address", active_address, m_addr);
      check_val("data_in", data_in, m_din);
      check_val("rd_resp_valid", rd_resp_valid, e_rv);
      check_val("rd_resp_data", rd_resp_data, m_rdata);

      m_tx_acc = 1'b0;
      m_rd_acc = 1'b0;
      if (reset) begin
         model_reset();
      end else begin
         m_tx_acc = tx_valid && e_txr;
         m_rd_acc = rd_req_valid && e_rdr;
         if (m_tx_acc) begin
            m_wr_cycle  = cyc + 1;
            m_wr_byte   = tx_data;
            m_idle_from = cyc + 2;
            m_ptr_read  = !m_ptr_read;
         end
         if (m_rd_acc) begin
            m_rd_cycle   = cyc + 1;
            m_rd_pending = 1'b1;
            m_resp_cycle = cyc + rd_lat + 2;
            m_resp_byte  = rd_force ? rd_force_byte : 8'($urandom);
            sched[cyc + 1 + rd_lat] = m_resp_byte;
            m_ptr_read   = !m_ptr_read;
         end
         if (e_rv && rd_resp_ready) begin
            m_rd_pending = 1'b0;
            m_idle_from  = cyc + 1;
         end
         // One credit returns per full frame time spent below the maximum.
         below  = (m_credits < max_credits);
         refill = below && (cyc == m_refill_end);
         nc     = m_credits - int'(m_tx_acc) + int'(refill);
         if (nc < max_credits && (!below || refill)) m_refill_end = cyc + frame;
         m_credits = nc;
      end
   endtask

   task automatic step(input bit rst, input bit txv, input logic [7:0] txd, input bit rqv,
                       input bit rsr);
      @(posedge clock);
      #1;
      reset         = rst;
      tx_valid      = txv;
      tx_data       = txd;
      rd_req_valid  = rqv;
      rd_resp_ready = rsr;
      data_out      = sched.exists(cyc) ? sched[cyc] : 8'($urandom);
      @(negedge clock);
      obs_we = write_enable;
      obs_re = read_enable;
      obs_rv = rd_resp_valid;
      model_cycle();
      cyc++;
   endtask

   int         acc_cnt, we_cnt, rv_cnt, first_acc, last_we;
   bit         got;
   logic [7:0] b;
   bit         kinds [$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rd_force      = 1'b0;
      rd_force_byte = 8'h00;
      model_reset();

      // Reset held with tx_valid asserted.
      repeat (3) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);

      // Single write.
      step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_val("single_we_n1", obs_we, 1'b1);
      check_val("single_din", data_in, 8'hA5);
      check_val("single_addr", active_address, tx_addr);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_val("single_we_n2", obs_we, 1'b0);

      // Credit exhaustion from a full credit pool.
      repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      acc_cnt = 0; we_cnt = 0; first_acc = -1; last_we = -1; b = 8'h10;
      for (int i = 0; i < 520; i++) begin
         step(1'b0, acc_cnt < 17, b, 1'b0, 1'b1);
         if (obs_we) begin
            we_cnt++;
            last_we = cyc - 1;
         end
         if (m_tx_acc) begin
            if (first_acc < 0) first_acc = cyc - 1;
            acc_cnt++;
            b = b + 8'd1;
         end
      end
      check_val("exh_writes", we_cnt, 17);
      check_val("exh_last_write_gap", last_we - first_acc, 482);

      // Read held under response backpressure.
      rd_force = 1'b1; rd_force_byte = 8'h3C; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         got = m_rd_acc;
      end
      rd_force = 1'b0;
      check_val("bp_accept_in_time", got, 1'b1);
      rv_cnt = 0;
      for (int i = 0; i < rd_lat + 6; i++) begin
         step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
         if (obs_rv) begin
            rv_cnt++;
            check_val("bp_data", rd_resp_data, 8'h3C);
         end
      end
      check_val("bp_held_cycles", rv_cnt, 5);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_val("bp_accept_cycle", obs_rv, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_val("bp_released", obs_rv, 1'b0);

      // Arbitration with both sources always requesting.
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 80; i++) begin
         step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b1);
         if (obs_re) kinds.push_back(1'b1);
         if (obs_we) kinds.push_back(1'b0);
      end
      check_val("arb_enough_grants", kinds.size() >= 6, 1'b1);
      if (kinds.size() > 0) check_val("arb_first_read", kinds[0], 1'b1);
      for (int i = 1; i < kinds.size(); i++) check_val("arb_alternate", kinds[i], !kinds[i-1]);

      // Reset while a read waits for data.
      repeat (10) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
         got = m_rd_acc;
      end
      check_val("rw_accept_in_time", got, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check_val("rw_read_enable", obs_re, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      rv_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
         rv_cnt += int'(obs_rv);
      end
      check_val("rw_no_response", rv_cnt, 0);
      we_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1);
         we_cnt += int'(obs_we);
      end
      check_val("rw_full_credits", we_cnt, max_credits);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(199) == 0, $urandom_range(1) == 1, 8'($urandom),
              $urandom_range(9) < 3, $urandom_range(9) < 6);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
